// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: request side (op/imm) and result side (ext/err).
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [IMM_W-1:0]  in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ext;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_imm, out_ready,
    input  in_ready, out_valid, out_ext, out_err
  );

  modport slave (
    input  in_valid, in_op, in_imm, out_ready,
    output in_ready, out_valid, out_ext, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// Buffered immediate extender: computes the extension on accept and queues
// results in a 2-entry FIFO so the producer can run ahead of a stalled consumer.
module ext_pipe #(
  parameter int          IMM_W     = 16,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] DEBUG_VAL = 32'hDEAD_BEEF,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  ext_pipe_if.slave        bus,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    OP_ZERO   = 3'd0,
    OP_SIGN   = 3'd1,
    OP_LUI    = 3'd2,
    OP_CLEAR  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] ext;
  } entry_t;

  localparam logic [DATA_W-1:0] DEBUG_EXT = DATA_W'(DEBUG_VAL);

  entry_t            mem [2];
  entry_t            new_entry;
  entry_t            head;
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;

  assign zext = {{(DATA_W-IMM_W){1'b0}}, bus.in_imm};
  assign sext = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};

  always_comb begin
    new_entry = '0;
    case (op_e'(bus.in_op))
      OP_ZERO:   new_entry.ext = zext;
      OP_SIGN:   new_entry.ext = sext;
      OP_LUI:    new_entry.ext = {bus.in_imm, {(DATA_W-IMM_W){1'b0}}};
      OP_CLEAR:  new_entry.ext = DEBUG_EXT;
      OP_BRANCH: new_entry.ext = {sext[DATA_W-3:0], 2'b00};
      OP_JUMP:   new_entry.ext = {zext[DATA_W-3:0], 2'b00};
      default: begin
        new_entry.ext = DEBUG_EXT;
        new_entry.err = 1'b1;
      end
    endcase
  end

  // in_ready comes only from the registered count, so a full buffer never
  // accepts in the same cycle it pops.
  assign bus.in_ready  = ~count[1];
  assign bus.out_valid = (count != 2'd0);
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign head        = mem[rd_ptr];
  assign bus.out_ext = bus.out_valid ? head.ext : '0;
  assign bus.out_err = bus.out_valid & head.err;

  // Storage needs no reset: an empty FIFO masks whatever the entries hold.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      err_cnt <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= ~wr_ptr;
        if (new_entry.err && (err_cnt != '1)) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe: a 16->32 instance for the main
// scenarios and an 8->16 instance for narrow-parameter extension.
module tb_ext_pipe;

  logic       clk;
  logic       reset;
  logic       flush_a;
  logic       flush_b;
  logic [7:0] err_cnt_a;
  logic [7:0] err_cnt_b;
  int         checks;
  int         errors;

  ext_pipe_if #(.IMM_W(16), .DATA_W(32)) bus_a ();
  ext_pipe_if #(.IMM_W(8),  .DATA_W(16)) bus_b ();

  ext_pipe #(.IMM_W(16), .DATA_W(32), .DEBUG_VAL(32'hDEAD_BEEF), .ERR_W(8)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush_a),
    .bus     (bus_a),
    .err_cnt (err_cnt_a)
  );

  ext_pipe #(.IMM_W(8), .DATA_W(16), .DEBUG_VAL(32'hDEAD_BEEF), .ERR_W(8)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush_b),
    .bus     (bus_b),
    .err_cnt (err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [15:0] imm, input logic ready);
    bus_a.in_valid  = valid;
    bus_a.in_op     = op;
    bus_a.in_imm    = imm;
    bus_a.out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  logic [2:0]  t2_ops [4] = '{3'd0, 3'd2, 3'd4, 3'd5};
  logic [31:0] t2_exp [4] = '{32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFC, 32'h0003_FFFC};

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    bus_b.in_valid  = 1'b0;
    bus_b.in_op     = 3'd0;
    bus_b.in_imm    = 8'h0;
    bus_b.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("rst_out_ext",   64'(bus_a.out_ext),   64'd0);
    checkOutput("rst_out_err",   64'(bus_a.out_err),   64'd0);
    checkOutput("rst_err_cnt",   64'(err_cnt_a),       64'd0);
    checkOutput("rst_in_ready",  64'(bus_a.in_ready),  64'd1);

    // Sign extension with one-cycle latency
    applyStimulus(1'b1, 3'd1, 16'h8001, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    checkOutput("sign_valid", 64'(bus_a.out_valid), 64'd1);
    checkOutput("sign_ext",   64'(bus_a.out_ext),   64'hFFFF_8001);
    tick();
    checkOutput("sign_drained", 64'(bus_a.out_valid), 64'd0);

    // Back-to-back ops streaming one per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t2_ops[i], 16'hFFFF, 1'b1);
      tick();
      checkOutput($sformatf("stream_valid%0d", i), 64'(bus_a.out_valid), 64'd1);
      checkOutput($sformatf("stream_ext%0d", i),   64'(bus_a.out_ext),   64'(t2_exp[i]));
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    checkOutput("stream_drained", 64'(bus_a.out_valid), 64'd0);

    // Stall: fill, hold head, then release in order
    applyStimulus(1'b1, 3'd0, 16'h1, 1'b0);
    tick();
    checkOutput("stall_ready1", 64'(bus_a.in_ready), 64'd1);
    checkOutput("stall_head1",  64'(bus_a.out_ext),  64'h1);
    applyStimulus(1'b1, 3'd0, 16'h2, 1'b0);
    tick();
    checkOutput("stall_full", 64'(bus_a.in_ready), 64'd0);
    applyStimulus(1'b1, 3'd0, 16'h3, 1'b0);
    tick();
    checkOutput("stall_still_full", 64'(bus_a.in_ready), 64'd0);
    checkOutput("stall_head_hold",  64'(bus_a.out_ext),  64'h1);
    applyStimulus(1'b1, 3'd0, 16'h3, 1'b1);
    checkOutput("full_pop_no_bypass", 64'(bus_a.in_ready), 64'd0);
    tick();
    checkOutput("release_head2", 64'(bus_a.out_ext),  64'h2);
    checkOutput("release_ready", 64'(bus_a.in_ready), 64'd1);
    tick();
    checkOutput("release_head3", 64'(bus_a.out_ext), 64'h3);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    checkOutput("release_drained", 64'(bus_a.out_valid), 64'd0);

    // Reserved ops versus CLEAR
    applyStimulus(1'b1, 3'd6, 16'h1234, 1'b1);
    tick();
    checkOutput("rsv6_ext", 64'(bus_a.out_ext), 64'hDEAD_BEEF);
    checkOutput("rsv6_err", 64'(bus_a.out_err), 64'd1);
    checkOutput("rsv6_cnt", 64'(err_cnt_a),     64'd1);
    applyStimulus(1'b1, 3'd7, 16'h5678, 1'b1);
    tick();
    checkOutput("rsv7_ext", 64'(bus_a.out_ext), 64'hDEAD_BEEF);
    checkOutput("rsv7_err", 64'(bus_a.out_err), 64'd1);
    checkOutput("rsv7_cnt", 64'(err_cnt_a),     64'd2);
    applyStimulus(1'b1, 3'd3, 16'h5678, 1'b1);
    tick();
    checkOutput("clear_ext", 64'(bus_a.out_ext), 64'hDEAD_BEEF);
    checkOutput("clear_err", 64'(bus_a.out_err), 64'd0);
    checkOutput("clear_cnt", 64'(err_cnt_a),     64'd2);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    tick();

    // Flush while full with a reserved op offered
    applyStimulus(1'b1, 3'd0, 16'h5, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd0, 16'h6, 1'b0);
    tick();
    checkOutput("flush_pre_full", 64'(bus_a.in_ready), 64'd0);
    flush_a = 1'b1;
    applyStimulus(1'b1, 3'd7, 16'h0, 1'b0);
    tick();
    flush_a = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("flush_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("flush_ready", 64'(bus_a.in_ready),  64'd1);
    checkOutput("flush_cnt",   64'(err_cnt_a),       64'd2);

    // Flush drops a same-cycle accept without counting it
    flush_a = 1'b1;
    applyStimulus(1'b1, 3'd6, 16'h0, 1'b0);
    tick();
    flush_a = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("flush_acc_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("flush_acc_cnt",   64'(err_cnt_a),       64'd2);
    applyStimulus(1'b1, 3'd0, 16'h9, 1'b1);
    tick();
    checkOutput("post_flush_ext", 64'(bus_a.out_ext), 64'h9);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    tick();

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 3'd7, 16'(i), 1'b1);
      tick();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    checkOutput("err_sat", 64'(err_cnt_a), 64'd255);
    tick();

    // Reset (with flush also asserted) while full
    applyStimulus(1'b1, 3'd0, 16'h7, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd7, 16'h8, 1'b0);
    tick();
    reset   = 1'b1;
    flush_a = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    tick();
    reset   = 1'b0;
    flush_a = 1'b0;
    checkOutput("rst_full_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("rst_full_ext",   64'(bus_a.out_ext),   64'd0);
    checkOutput("rst_full_err",   64'(bus_a.out_err),   64'd0);
    checkOutput("rst_full_cnt",   64'(err_cnt_a),       64'd0);
    checkOutput("rst_full_ready", 64'(bus_a.in_ready),  64'd1);

    // Narrow instance: IMM_W=8, DATA_W=16
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_imm    = 8'h80;
    bus_b.in_op     = 3'd1;
    tick();
    checkOutput("narrow_sign", 64'(bus_b.out_ext), 64'hFF80);
    bus_b.in_op = 3'd2;
    tick();
    checkOutput("narrow_lui", 64'(bus_b.out_ext), 64'h8000);
    bus_b.in_op = 3'd4;
    tick();
    checkOutput("narrow_branch", 64'(bus_b.out_ext), 64'hFE00);
    bus_b.in_op = 3'd5;
    tick();
    checkOutput("narrow_jump", 64'(bus_b.out_ext), 64'h0200);
    bus_b.in_op = 3'd7;
    tick();
    checkOutput("narrow_rsv_ext", 64'(bus_b.out_ext), 64'hBEEF);
    checkOutput("narrow_rsv_err", 64'(bus_b.out_err), 64'd1);
    checkOutput("narrow_rsv_cnt", 64'(err_cnt_b),     64'd1);
    bus_b.in_valid = 1'b0;
    tick();
    checkOutput("narrow_drained", 64'(bus_b.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
